// File: rtl/opf_pkg.sv
// Shared widths and operand-select helpers for the operand fetch stage.
package opf_pkg;
  localparam int NUM_REGS = 16;
  localparam int REG_W    = 32;
  localparam int IDX_W    = 5;
  localparam int OP_W     = 6;
  localparam int SEL_W    = $clog2(NUM_REGS);

  localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(NUM_REGS);

  function automatic logic idx_legal(input logic [IDX_W-1:0] idx);
    return idx < NUM_REGS_IDX;
  endfunction

  // Index 0 and out-of-range indices read as zero; a same-cycle writeback beats the bank.
  function automatic logic [REG_W-1:0] sel_operand(
    input logic [IDX_W-1:0] idx,
    input logic [REG_W-1:0] rd,
    input logic             wb_we,
    input logic [IDX_W-1:0] wb_dr,
    input logic [REG_W-1:0] wb_data
  );
    if (idx == '0 || !idx_legal(idx)) return '0;
    else if (wb_we && wb_dr == idx)   return wb_data;
    else                              return rd;
  endfunction
endpackage

// File: rtl/opf_scoreboard.sv
// Pending-write scoreboard: tracks registers with an in-flight write and flags RAW hazards.
module opf_scoreboard
  import opf_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set_i,
  input  logic [IDX_W-1:0] set_idx_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  input  logic [IDX_W-1:0] sr1_i,
  input  logic [IDX_W-1:0] sr2_i,
  output logic             stall_o
);
  logic [NUM_REGS-1:0] pend_q, pend_d;

  function automatic logic hazard(input logic [IDX_W-1:0] idx,
                                  input logic [NUM_REGS-1:0] pend,
                                  input logic clr,
                                  input logic [IDX_W-1:0] clr_idx);
    return (idx != '0) && idx_legal(idx) && pend[idx[SEL_W-1:0]] &&
           !(clr && clr_idx == idx);
  endfunction

  // Clear first so a same-cycle set of the same bit wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_i && idx_legal(clr_idx_i)) pend_d[clr_idx_i[SEL_W-1:0]] = 1'b0;
    if (set_i) pend_d[set_idx_i[SEL_W-1:0]] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign stall_o = hazard(sr1_i, pend_q, clr_i, clr_idx_i) ||
                   hazard(sr2_i, pend_q, clr_i, clr_idx_i);
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads/forwards sources, stalls on RAW hazards, registers the ALU bundle.
module operand_fetch
  import opf_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_sr1,
  input  logic [IDX_W-1:0] in_sr2,
  input  logic [IDX_W-1:0] in_dr,
  input  logic             in_we,
  input  logic [OP_W-1:0]  in_op,
  input  logic [REG_W-1:0] in_imm,
  output logic [IDX_W-1:0] rf_sr1,
  output logic [IDX_W-1:0] rf_sr2,
  input  logic [REG_W-1:0] rf_rd1,
  input  logic [REG_W-1:0] rf_rd2,
  input  logic             wb_we,
  input  logic [IDX_W-1:0] wb_dr,
  input  logic [REG_W-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_a,
  output logic [REG_W-1:0] out_b,
  output logic [REG_W-1:0] out_imm,
  output logic [OP_W-1:0]  out_op,
  output logic [IDX_W-1:0] out_dr,
  output logic             out_we,
  output logic             out_illegal,
  output logic [15:0]      stall_cnt
);
  logic             stall, accept, illegal, set_en;
  logic             valid_q, valid_d, we_q, we_d, ill_q, ill_d;
  logic [REG_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [IDX_W-1:0] dr_q, dr_d, sr1_q, sr1_d, sr2_q, sr2_d;
  logic [15:0]      cnt_q, cnt_d;

  assign rf_sr1   = in_sr1;
  assign rf_sr2   = in_sr2;
  assign in_ready = (!valid_q || out_ready) && !stall;
  assign accept   = in_valid && in_ready;
  assign illegal  = !idx_legal(in_sr1) || !idx_legal(in_sr2) || (in_we && !idx_legal(in_dr));
  assign set_en   = accept && in_we && (in_dr != '0) && !illegal;

  opf_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_i     (set_en),
    .set_idx_i (in_dr),
    .clr_i     (wb_we),
    .clr_idx_i (wb_dr),
    .sr1_i     (in_sr1),
    .sr2_i     (in_sr2),
    .stall_o   (stall)
  );

  always_comb begin
    valid_d = valid_q;
    a_d = a_q;  b_d = b_q;  imm_d = imm_q;  op_d = op_q;
    dr_d = dr_q;  we_d = we_q;  ill_d = ill_q;
    sr1_d = sr1_q;  sr2_d = sr2_q;
    cnt_d = cnt_q;
    if (accept) begin
      valid_d = 1'b1;
      a_d     = sel_operand(in_sr1, rf_rd1, wb_we, wb_dr, wb_data);
      b_d     = sel_operand(in_sr2, rf_rd2, wb_we, wb_dr, wb_data);
      imm_d   = in_imm;
      op_d    = in_op;
      dr_d    = in_dr;
      we_d    = in_we;
      ill_d   = illegal;
      sr1_d   = in_sr1;
      sr2_d   = in_sr2;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // Held operands for index 0 / illegal are already zero, so reselecting keeps them zero.
      a_d = sel_operand(sr1_q, a_q, wb_we, wb_dr, wb_data);
      b_d = sel_operand(sr2_q, b_q, wb_we, wb_dr, wb_data);
    end
    if (in_valid && stall && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      a_q <= '0;  b_q <= '0;  imm_q <= '0;  op_q <= '0;
      dr_q <= '0;  we_q <= 1'b0;  ill_q <= 1'b0;
      sr1_q <= '0;  sr2_q <= '0;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      a_q <= a_d;  b_q <= b_d;  imm_q <= imm_d;  op_q <= op_d;
      dr_q <= dr_d;  we_q <= we_d;  ill_q <= ill_d;
      sr1_q <= sr1_d;  sr2_q <= sr2_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_a       = a_q;
  assign out_b       = b_q;
  assign out_imm     = imm_q;
  assign out_op      = op_q;
  assign out_dr      = dr_q;
  assign out_we      = we_q;
  assign out_illegal = ill_q;
  assign stall_cnt   = cnt_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: single-cycle vector table plus multi-cycle hazard sequences.
module tb_operand_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_we, wb_we, out_valid, out_ready, out_we, out_illegal;
  logic [4:0]  in_sr1, in_sr2, in_dr, rf_sr1, rf_sr2, wb_dr, out_dr;
  logic [5:0]  in_op, out_op;
  logic [31:0] in_imm, rf_rd1, rf_rd2, wb_data, out_a, out_b, out_imm;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr), .in_we(in_we),
    .in_op(in_op), .in_imm(in_imm),
    .rf_sr1(rf_sr1), .rf_sr2(rf_sr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_dr(wb_dr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
    .out_op(out_op), .out_dr(out_dr), .out_we(out_we),
    .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  sr1, sr2, dr;
    logic        we;
    logic [5:0]  op;
    logic [31:0] imm, rd1, rd2;
    logic        wb_we;
    logic [4:0]  wb_dr;
    logic [31:0] wb_data, exp_a, exp_b;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] sr1, input logic [4:0] sr2, input logic [4:0] dr,
                       input logic we, input logic [31:0] rd1, input logic [31:0] rd2);
    in_sr1 = sr1; in_sr2 = sr2; in_dr = dr; in_we = we; rf_rd1 = rd1; rf_rd2 = rd2;
  endtask

  initial begin
    vecs[0] = '{5'd3,  5'd4,  5'd9,  1'b0, 6'h01, 32'h100, 32'h11, 32'h22, 1'b1, 5'd3, 32'hDEADBEEF, 32'hDEADBEEF, 32'h22, 1'b0};
    vecs[1] = '{5'd0,  5'd20, 5'd9,  1'b0, 6'h02, 32'h200, 32'hFFFF, 32'h1234, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[2] = '{5'd15, 5'd1,  5'd0,  1'b0, 6'h03, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h5, 1'b1, 5'd1, 32'h77, 32'hA5A5A5A5, 32'h77, 1'b0};
    vecs[3] = '{5'd16, 5'd0,  5'd0,  1'b0, 6'h04, 32'h0, 32'hABC, 32'hDEF, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[4] = '{5'd2,  5'd2,  5'd0,  1'b0, 6'h05, 32'h5, 32'hCC, 32'hDD, 1'b0, 5'd2, 32'h99, 32'hCC, 32'hDD, 1'b0};
    vecs[5] = '{5'd7,  5'd8,  5'd20, 1'b1, 6'h06, 32'h6, 32'h70, 32'h80, 1'b0, 5'd0, 32'h0, 32'h70, 32'h80, 1'b1};
    vecs[6] = '{5'd31, 5'd3,  5'd6,  1'b1, 6'h07, 32'h7, 32'h1, 32'h33, 1'b0, 5'd0, 32'h0, 32'h0, 32'h33, 1'b1};
    vecs[7] = '{5'd6,  5'd0,  5'd0,  1'b1, 6'h08, 32'h8, 32'h66, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h66, 32'h0, 1'b0};
    vecs[8] = '{5'd0,  5'd0,  5'd0,  1'b1, 6'h3F, 32'h9, 32'h1, 32'h2, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0);
    in_op = '0; in_imm = '0; wb_we = 1'b0; wb_dr = '0; wb_data = '0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_out_a", out_a, 32'h0);
    chk("rst_out_illegal", 32'(out_illegal), 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      drive(vecs[i].sr1, vecs[i].sr2, vecs[i].dr, vecs[i].we, vecs[i].rd1, vecs[i].rd2);
      in_op = vecs[i].op; in_imm = vecs[i].imm;
      wb_we = vecs[i].wb_we; wb_dr = vecs[i].wb_dr; wb_data = vecs[i].wb_data;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'h1);
      chk($sformatf("v%0d_rf_sr1", i), 32'(rf_sr1), 32'(vecs[i].sr1));
      chk($sformatf("v%0d_rf_sr2", i), 32'(rf_sr2), 32'(vecs[i].sr2));
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'h1);
      chk($sformatf("v%0d_out_a", i), out_a, vecs[i].exp_a);
      chk($sformatf("v%0d_out_b", i), out_b, vecs[i].exp_b);
      chk($sformatf("v%0d_out_imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d_out_op", i), 32'(out_op), 32'(vecs[i].op));
      chk($sformatf("v%0d_out_dr", i), 32'(out_dr), 32'(vecs[i].dr));
      chk($sformatf("v%0d_out_we", i), 32'(out_we), 32'(vecs[i].we));
      chk($sformatf("v%0d_out_illegal", i), 32'(out_illegal), 32'(vecs[i].exp_ill));
    end
    wb_we = 1'b0; in_op = 6'h10; in_imm = 32'h0;

    // RAW stall on r5, released by same-cycle writeback forwarding
    drive(5'd1, 5'd0, 5'd5, 1'b1, 32'h1, 32'h0);
    tick();
    drive(5'd5, 5'd0, 5'd0, 1'b0, 32'h10, 32'h0);
    #1;
    chk("raw_in_ready_stall", 32'(in_ready), 32'h0);
    tick();
    chk("raw_out_valid_drain", 32'(out_valid), 32'h0);
    chk("raw_stall_cnt_1", 32'(stall_cnt), 32'h1);
    tick();
    chk("raw_stall_cnt_2", 32'(stall_cnt), 32'h2);
    wb_we = 1'b1; wb_dr = 5'd5; wb_data = 32'h42;
    #1;
    chk("raw_in_ready_release", 32'(in_ready), 32'h1);
    tick();
    chk("raw_out_valid", 32'(out_valid), 32'h1);
    chk("raw_out_a_fwd", out_a, 32'h42);
    chk("raw_stall_cnt_hold", 32'(stall_cnt), 32'h2);
    wb_we = 1'b0;
    #1;
    chk("raw_bit5_cleared", 32'(in_ready), 32'h1);

    // Back-pressure: bundle held, writeback to held sr2 updates out_b
    drive(5'd3, 5'd7, 5'd0, 1'b0, 32'h30, 32'h70);
    in_op = 6'h2A; in_imm = 32'hCAFE;
    tick();
    chk("bp_out_a", out_a, 32'h30);
    out_ready = 1'b0;
    drive(5'd9, 5'd10, 5'd0, 1'b0, 32'h1, 32'h2);
    in_op = 6'h11; in_imm = 32'h1;
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("bp_hold1_a", out_a, 32'h30);
    chk("bp_hold1_b", out_b, 32'h70);
    tick();
    chk("bp_hold2_op", 32'(out_op), 32'h2A);
    chk("bp_hold2_imm", out_imm, 32'hCAFE);
    wb_we = 1'b1; wb_dr = 5'd7; wb_data = 32'h99;
    tick();
    wb_we = 1'b0;
    chk("bp_wb_out_b", out_b, 32'h99);
    chk("bp_wb_out_a", out_a, 32'h30);
    chk("bp_out_valid_held", 32'(out_valid), 32'h1);
    chk("bp_stall_cnt", 32'(stall_cnt), 32'h2);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    chk("bp_out_valid_clear", 32'(out_valid), 32'h0);

    // Set wins over a same-cycle clear of the same pending bit
    in_valid = 1'b1;
    drive(5'd0, 5'd0, 5'd4, 1'b1, 32'h0, 32'h0);
    wb_we = 1'b1; wb_dr = 5'd4; wb_data = 32'h55;
    tick();
    wb_we = 1'b0;
    drive(5'd4, 5'd0, 5'd0, 1'b0, 32'h4, 32'h0);
    #1;
    chk("sw_in_ready_stall", 32'(in_ready), 32'h0);
    tick();
    chk("sw_stall_cnt", 32'(stall_cnt), 32'h3);
    wb_we = 1'b1; wb_dr = 5'd4; wb_data = 32'h44;
    #1;
    chk("sw_in_ready_release", 32'(in_ready), 32'h1);
    tick();
    wb_we = 1'b0;
    chk("sw_out_a", out_a, 32'h44);

    // Reset during a RAW stall with in_valid still asserted
    drive(5'd0, 5'd0, 5'd5, 1'b1, 32'h0, 32'h0);
    tick();
    drive(5'd5, 5'd0, 5'd0, 1'b0, 32'h5, 32'h0);
    #1;
    chk("rs_in_ready_stall", 32'(in_ready), 32'h0);
    tick();
    chk("rs_stall_cnt", 32'(stall_cnt), 32'h4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rs_in_ready", 32'(in_ready), 32'h1);
    chk("rs_out_valid", 32'(out_valid), 32'h0);
    chk("rs_stall_cnt_zero", 32'(stall_cnt), 32'h0);
    chk("rs_out_a", out_a, 32'h0);
    chk("rs_out_op", 32'(out_op), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
